// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: size codes, FSM states,
// wait-counter width and the latched request payload.
package dmem_pkg;

   localparam int unsigned WAIT_CNT_W = 4;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        is_unsigned;
      logic [31:0] wdata;
   } req_attr_t;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      return ((size == SZ_HALF) && lane[0]) || ((size == SZ_WORD) && (lane != 2'b00));
   endfunction

   // Lane after dropping the address bits that the access size cannot use.
   function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_HALF: return {lane[1], 1'b0};
         SZ_WORD: return 2'b00;
         default: return lane;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic for one 32-bit little-endian word: merges byte/half
// write data into the addressed lanes and extracts/extends read data.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   input  logic [1:0]  i_lane,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   output logic [31:0] o_merged,
   output logic [31:0] o_rdata
);

   logic [4:0]  w_shift;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_mask;

   always_comb begin
      w_shift  = {i_lane, 3'b000};
      w_byte   = 8'(i_word >> w_shift);
      w_half   = 16'(i_word >> w_shift);
      w_mask   = 32'h0000_0000;
      o_rdata  = 32'h0000_0000;
      case (i_size)
         SZ_BYTE: begin
            w_mask  = 32'h0000_00FF << w_shift;
            o_rdata = i_unsigned ? {24'h00_0000, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            w_mask  = 32'h0000_FFFF << w_shift;
            o_rdata = i_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
         end
         SZ_WORD: begin
            w_mask  = 32'hFFFF_FFFF;
            o_rdata = i_word;
         end
         default: begin
            w_mask  = 32'h0000_0000;
            o_rdata = 32'h0000_0000;
         end
      endcase
      // Unaddressed lanes keep their stored value.
      o_merged = (i_word & ~w_mask) | ((i_wdata << w_shift) & w_mask);
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
// Define DMEM_MISALIGN_CHECK_EN to error misaligned requests instead of aligning them.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err
);

   localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
   localparam int unsigned DEPTH   = 2 ** WORD_AW;

   state_e                  r_state;
   logic [WAIT_CNT_W-1:0]   r_cnt;
   logic                    r_req_ready;
   logic                    r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;
   logic                    r_rsp_err;
   req_attr_t               r_req;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

   state_e                  w_state_nxt;
   logic [WAIT_CNT_W-1:0]   w_cnt_nxt;
   logic                    w_ready_nxt;
   logic                    w_valid_nxt;
   logic [DATA_WIDTH-1:0]   w_rdata_nxt;
   logic                    w_err_nxt;
   logic                    w_accept;
   logic                    w_access;
   logic                    w_err;
   logic                    w_mem_we;
   logic [WORD_AW-1:0]      w_widx;
   logic [1:0]              w_lane;
   logic [DATA_WIDTH-1:0]   w_word;
   logic [DATA_WIDTH-1:0]   w_merged;
   logic [DATA_WIDTH-1:0]   w_rdata;
   req_attr_t               w_req_in;

   assign w_widx = r_addr[ADDR_WIDTH-1:2];
   assign w_lane = align_lane(r_req.size, r_addr[1:0]);
   assign w_word = r_mem[w_widx];

`ifdef DMEM_MISALIGN_CHECK_EN
   assign w_err = (r_req.size == SZ_RSVD) || is_misaligned(r_req.size, r_addr[1:0]);
`else
   assign w_err = (r_req.size == SZ_RSVD);
`endif

   dmem_lane_align u_lane_align (
      .i_word     (w_word),
      .i_wdata    (r_req.wdata),
      .i_lane     (w_lane),
      .i_size     (r_req.size),
      .i_unsigned (r_req.is_unsigned),
      .o_merged   (w_merged),
      .o_rdata    (w_rdata)
   );

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_valid_nxt = r_rsp_valid;
      w_rdata_nxt = r_rsp_rdata;
      w_err_nxt   = r_rsp_err;
      w_accept    = 1'b0;
      w_access    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid && r_req_ready) begin
               w_accept    = 1'b1;
               w_cnt_nxt   = WAIT_CNT_W'(WAIT_CYCLES);
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_access    = 1'b1;
               w_state_nxt = ST_RESP;
               w_valid_nxt = 1'b1;
               w_err_nxt   = w_err;
               w_rdata_nxt = (w_err || r_req.we) ? '0 : w_rdata;
            end else begin
               w_cnt_nxt = r_cnt - WAIT_CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
               w_valid_nxt = 1'b0;
               w_rdata_nxt = '0;
               w_err_nxt   = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      // Ready follows the registered state, so a completed response never reaccepts on the same edge.
      w_ready_nxt = (w_state_nxt == ST_IDLE);
   end

   assign w_mem_we = w_access && r_req.we && !w_err;

   assign w_req_in = '{we: req_we, size: req_size, is_unsigned: req_unsigned, wdata: req_wdata};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_req_ready <= w_ready_nxt;
         r_rsp_valid <= w_valid_nxt;
         r_rsp_rdata <= w_rdata_nxt;
         r_rsp_err   <= w_err_nxt;
      end
   end

   // Request capture on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_req  <= '0;
         r_addr <= '0;
      end else if (w_accept) begin
         r_req  <= w_req_in;
         r_addr <= req_addr;
      end
   end

   // Storage survives reset.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_widx] <= w_merged;
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-level memory model with per-cycle output compare,
// plus directed transactions with hand-computed results.
module tb_dmem_responder;

   localparam int unsigned WAIT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   dmem_responder #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (16),
      .WAIT_CYCLES (WAIT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: byte-addressed store, response due WAIT+1 edges after accept.
   logic [7:0]  m_mem [int];
   bit          m_pending = 1'b0;
   bit          m_resp    = 1'b0;
   bit          m_ready   = 1'b0;
   logic [31:0] m_rdata   = 32'h0;
   logic        m_err     = 1'b0;
   int          m_edges   = 0;
   int          m_acc_edge = 0;
   logic        m_we;
   logic [15:0] m_addr;
   logic [1:0]  m_size;
   logic        m_uns;
   logic [31:0] m_wd;

   function automatic logic [7:0] rd_byte(input int a);
      return m_mem.exists(a) ? m_mem[a] : 8'h00;
   endfunction

   task automatic model_access();
      int nb;
      int a;
      nb = (m_size == 2'd0) ? 1 : (m_size == 2'd1) ? 2 : 4;
      m_err = (m_size == 2'd3);
`ifdef DMEM_MISALIGN_CHECK_EN
      if ((m_size != 2'd3) && ((int'(m_addr) % nb) != 0)) m_err = 1'b1;
`endif
      a = int'(m_addr) - (int'(m_addr) % nb);
      m_rdata = 32'h0;
      if (m_err) return;
      if (m_we) begin
         for (int i = 0; i < nb; i++) m_mem[a + i] = m_wd[8*i +: 8];
      end else begin
         for (int i = 0; i < nb; i++) m_rdata = m_rdata | (32'(rd_byte(a + i)) << (8 * i));
         if ((nb < 4) && !m_uns && m_rdata[8*nb-1])
            m_rdata = m_rdata | ~((32'h1 << (8 * nb)) - 32'h1);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pending = 1'b0;
         m_resp    = 1'b0;
         m_ready   = 1'b0;
         m_rdata   = 32'h0;
         m_err     = 1'b0;
         m_edges   = 0;
      end else begin
         m_edges++;
         if (m_resp) begin
            if (rsp_ready) begin
               m_resp = 1'b0;
            end
         end else if (m_pending) begin
            if (m_edges == m_acc_edge + 1 + int'(WAIT)) begin
               model_access();
               m_pending = 1'b0;
               m_resp    = 1'b1;
            end
         end else if (m_ready && req_valid) begin
            m_we = req_we; m_addr = req_addr; m_size = req_size;
            m_uns = req_unsigned; m_wd = req_wdata;
            m_pending  = 1'b1;
            m_acc_edge = m_edges;
         end
         m_ready = (m_edges >= 1) && !m_pending && !m_resp;
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      chk("cyc_req_ready", 32'(req_ready), 32'(m_ready));
      chk("cyc_rsp_valid", 32'(rsp_valid), 32'(m_resp));
      if (m_resp || rst) begin
         chk("cyc_rsp_rdata", rsp_rdata, m_rdata);
         chk("cyc_rsp_err", 32'(rsp_err), 32'(m_err));
      end
   end

   task automatic issue(input logic we, input logic [15:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("req_ready_timeout", 32'(ok), 32'h1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("rsp_valid_timeout", 32'(rsp_valid), 32'h1);
   endtask

   task automatic finish_rsp(input int hold, output logic [31:0] rd, output logic er);
      rd = rsp_rdata;
      er = rsp_err;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_rsp_valid", 32'(rsp_valid), 32'h1);
         chk("hold_req_ready", 32'(req_ready), 32'h0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("post_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("post_req_ready", 32'(req_ready), 32'h1);
   endtask

   task automatic txn(input logic we, input logic [15:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
      int lat;
      issue(we, addr, size, uns, wd);
      wait_rsp(lat);
      chk("latency", 32'(lat), 32'(WAIT + 1));
      finish_rsp(hold, rd, er);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_size = 2'b00;
      req_unsigned = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b0;

      #2 rst = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      txn(1'b1, 16'h0010, 2'b10, 1'b0, 32'hDEADBEEF, 0, rd, er);
      chk("wr_word_rdata", rd, 32'h0);
      chk("wr_word_err", 32'(er), 32'h0);
      txn(1'b0, 16'h0010, 2'b10, 1'b0, 32'h0, 0, rd, er);
      chk("rd_word_0010", rd, 32'hDEADBEEF);
      txn(1'b0, 16'h0013, 2'b00, 1'b0, 32'h0, 0, rd, er);
      chk("rd_byte_0013_s", rd, 32'hFFFFFFDE);
      txn(1'b0, 16'h0013, 2'b00, 1'b1, 32'h0, 0, rd, er);
      chk("rd_byte_0013_u", rd, 32'h000000DE);
      txn(1'b1, 16'h0012, 2'b01, 1'b0, 32'h00001234, 0, rd, er);
      txn(1'b0, 16'h0010, 2'b10, 1'b0, 32'h0, 5, rd, er);
      chk("rd_word_merged", rd, 32'h1234BEEF);

      // Reset during the wait phase of a write drops it.
      issue(1'b1, 16'h0010, 2'b10, 1'b0, 32'h0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rstwait_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rstwait_req_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      txn(1'b0, 16'h0010, 2'b10, 1'b0, 32'h0, 0, rd, er);
      chk("rd_after_rstwait", rd, 32'h1234BEEF);

      txn(1'b1, 16'h0020, 2'b10, 1'b0, 32'h11223344, 0, rd, er);
      txn(1'b1, 16'h0021, 2'b00, 1'b0, 32'hFFFFFF80, 0, rd, er);
      txn(1'b0, 16'h0020, 2'b10, 1'b0, 32'h0, 0, rd, er);
      chk("rd_word_0020", rd, 32'h11228044);
      txn(1'b0, 16'h0020, 2'b01, 1'b0, 32'h0, 0, rd, er);
      chk("rd_half_0020_s", rd, 32'hFFFF8044);
      txn(1'b0, 16'h0022, 2'b01, 1'b0, 32'h0, 0, rd, er);
      chk("rd_half_0022_s", rd, 32'h00001122);
      txn(1'b0, 16'h0021, 2'b00, 1'b1, 32'h0, 0, rd, er);
      chk("rd_byte_0021_u", rd, 32'h00000080);

      txn(1'b1, 16'h0020, 2'b11, 1'b0, 32'hFFFFFFFF, 0, rd, er);
      chk("rsvd_err", 32'(er), 32'h1);
      chk("rsvd_rdata", rd, 32'h0);
      txn(1'b0, 16'h0020, 2'b10, 1'b0, 32'h0, 0, rd, er);
      chk("rd_after_rsvd", rd, 32'h11228044);

      // Reset while a response is presented clears it at once.
      issue(1'b0, 16'h0020, 2'b11, 1'b0, 32'h0);
      wait_rsp(lat);
      chk("rsvd_rd_err", 32'(rsp_err), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("rstresp_valid", 32'(rsp_valid), 32'h0);
      chk("rstresp_err", 32'(rsp_err), 32'h0);
      chk("rstresp_rdata", rsp_rdata, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      txn(1'b1, 16'h0011, 2'b01, 1'b0, 32'h0000AAAA, 0, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
      chk("mis_half_err", 32'(er), 32'h1);
      chk("mis_half_rdata", rd, 32'h0);
      txn(1'b0, 16'h0010, 2'b10, 1'b0, 32'h0, 0, rd, er);
      chk("rd_after_mis", rd, 32'h1234BEEF);
      txn(1'b0, 16'h0013, 2'b10, 1'b0, 32'h0, 0, rd, er);
      chk("mis_word_err", 32'(er), 32'h1);
      chk("mis_word_rdata", rd, 32'h0);
`else
      chk("mis_half_err", 32'(er), 32'h0);
      txn(1'b0, 16'h0010, 2'b10, 1'b0, 32'h0, 0, rd, er);
      chk("rd_after_mis", rd, 32'h1234AAAA);
      txn(1'b0, 16'h0013, 2'b10, 1'b0, 32'h0, 0, rd, er);
      chk("mis_word_err", 32'(er), 32'h0);
      chk("mis_word_rdata", rd, 32'h1234AAAA);
`endif

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
